// File: rtl/soc_bus_arbiter_if.sv
// Bus bundle for soc_bus_arbiter: two requesting masters, one shared slave port and status.
// Modport "master" is the arbiter's view (it owns the shared bus); "slave" is the surrounding system's view.
interface soc_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_we;
  logic              m0_ack;
  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_we;
  logic              m1_ack;
  logic [DATA_W-1:0] m_rdata;
  logic              m_err;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic              s_we;
  logic              s_re;
  logic [DATA_W-1:0] s_rdata;
  logic              s_ready;
  logic              owner;
  logic              busy;

  modport master (
    input  m0_req, m0_addr, m0_wdata, m0_we,
    input  m1_req, m1_addr, m1_wdata, m1_we,
    input  s_rdata, s_ready,
    output m0_ack, m1_ack, m_rdata, m_err,
    output s_addr, s_wdata, s_we, s_re,
    output owner, busy
  );

  modport slave (
    output m0_req, m0_addr, m0_wdata, m0_we,
    output m1_req, m1_addr, m1_wdata, m1_we,
    output s_rdata, s_ready,
    input  m0_ack, m1_ack, m_rdata, m_err,
    input  s_addr, s_wdata, s_we, s_re,
    input  owner, busy
  );
endinterface

// File: rtl/soc_bus_arbiter.sv
// Two-master round-robin arbiter for the shared SoC bus; one single-beat transfer at a time,
// all outputs registered, one-cycle ack to the winning master.
// Optional feature macro: ARB_TIMEOUT_EN (abort an ACCESS after TIMEOUT cycles without s_ready).
module soc_bus_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic              clk,
  input logic              reset,
  soc_bus_arbiter_if.master bus
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("soc_bus_arbiter: TIMEOUT must be in 2..255");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0] m_rdata_q, m_rdata_d;
  logic              m_err_q, m_err_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
  logic              s_we_q, s_we_d;
  logic              s_re_q, s_re_d;
  logic              owner_q, owner_d;
  logic              busy_q, busy_d;

  logic              any_req;
  logic              gnt;
  logic              gnt_we;
  logic              timeout_hit;

  // Lone requester wins outright; contention goes to the round-robin pointer.
  assign any_req = bus.m0_req | bus.m1_req;
  assign gnt     = (bus.m0_req & bus.m1_req) ? rr_q : bus.m1_req;
  assign gnt_we  = gnt ? bus.m1_we : bus.m0_we;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q;

  // Count stalled ACCESS cycles; IDLE always precedes ACCESS, so clearing there clears on entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if (state_q == ACCESS && !bus.s_ready) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign timeout_hit = (cnt_q == TO_LAST) && !bus.s_ready;
`else
  assign timeout_hit = 1'b0;
`endif

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
      m_rdata_q <= '0;
      m_err_q   <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_we_q    <= 1'b0;
      s_re_q    <= 1'b0;
      owner_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      m0_ack_q  <= m0_ack_d;
      m1_ack_q  <= m1_ack_d;
      m_rdata_q <= m_rdata_d;
      m_err_q   <= m_err_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_we_q    <= s_we_d;
      s_re_q    <= s_re_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic: IDLE -> ACCESS -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (bus.s_ready || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; everything holds unless the current state changes it.
  always_comb begin
    rr_d      = rr_q;
    m0_ack_d  = 1'b0;
    m1_ack_d  = 1'b0;
    m_rdata_d = m_rdata_q;
    m_err_d   = m_err_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_we_d    = s_we_q;
    s_re_d    = s_re_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          s_addr_d  = gnt ? bus.m1_addr  : bus.m0_addr;
          s_wdata_d = gnt ? bus.m1_wdata : bus.m0_wdata;
          s_we_d    = gnt_we;
          s_re_d    = ~gnt_we;
          owner_d   = gnt;
          busy_d    = 1'b1;
        end
      end
      ACCESS: begin
        if (bus.s_ready) begin
          if (s_re_q) m_rdata_d = bus.s_rdata;
          m_err_d  = 1'b0;
          s_we_d   = 1'b0;
          s_re_d   = 1'b0;
          m0_ack_d = ~owner_q;
          m1_ack_d = owner_q;
        end else if (timeout_hit) begin
          m_rdata_d = DATA_W'(32'hDEAD_BEEF);
          m_err_d   = 1'b1;
          s_we_d    = 1'b0;
          s_re_d    = 1'b0;
          m0_ack_d  = ~owner_q;
          m1_ack_d  = owner_q;
        end
      end
      DONE: begin
        busy_d = 1'b0;
        rr_d   = ~owner_q;
      end
      default: ;
    endcase
  end

  assign bus.m0_ack  = m0_ack_q;
  assign bus.m1_ack  = m1_ack_q;
  assign bus.m_rdata = m_rdata_q;
  assign bus.m_err   = m_err_q;
  assign bus.s_addr  = s_addr_q;
  assign bus.s_wdata = s_wdata_q;
  assign bus.s_we    = s_we_q;
  assign bus.s_re    = s_re_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Directed bench for soc_bus_arbiter: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_soc_bus_arbiter;

  localparam logic [31:0] RAM   = 32'h2000_0000;
  localparam logic [31:0] TIMER = 32'h4000_0000;
  localparam logic [31:0] LED   = 32'h4001_0000;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  soc_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  soc_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected flags are {busy, owner, s_we, s_re, m0_ack, m1_ack, m_err} after the edge.
  typedef struct {
    logic        rst;
    logic        r0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic        w0;
    logic        r1;
    logic [31:0] a1;
    logic [31:0] d1;
    logic        w1;
    logic [31:0] srd;
    logic        srdy;
    logic [6:0]  flags;
    logic [31:0] saddr;
    logic [31:0] swdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic rst, input logic r0, input logic [31:0] a0,
                              input logic [31:0] d0, input logic w0, input logic r1,
                              input logic [31:0] a1, input logic [31:0] d1, input logic w1,
                              input logic [31:0] srd, input logic srdy, input logic [6:0] flags,
                              input logic [31:0] saddr, input logic [31:0] swdata,
                              input logic [31:0] rdata);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.a0 = a0; v.d0 = d0; v.w0 = w0;
    v.r1 = r1; v.a1 = a1; v.d1 = d1; v.w1 = w1; v.srd = srd; v.srdy = srdy;
    v.flags = flags; v.saddr = saddr; v.swdata = swdata; v.rdata = rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] flags_now();
    return {bus.busy, bus.owner, bus.s_we, bus.s_re, bus.m0_ack, bus.m1_ack, bus.m_err};
  endfunction

  int we_cnt, ack0_cnt, ack1_cnt, n;
  logic found;

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.m0_req = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_we = 1'b0;
    bus.m1_req = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_we = 1'b0;
    bus.s_rdata = '0;  bus.s_ready = 1'b0;

    // Reset with both requesting, CPU read first, then continuous LED writes from both masters.
    vecs[0]  = mk(1, 1, RAM, 32'h00, 0, 1, LED, 32'h11, 1, 32'h00, 0, 7'b0000000, 32'h0, 32'h00, 32'h00);
    vecs[1]  = mk(0, 1, RAM, 32'h00, 0, 1, LED, 32'h11, 1, 32'h00, 0, 7'b1001000, RAM,   32'h00, 32'h00);
    vecs[2]  = mk(0, 1, RAM, 32'h00, 0, 1, LED, 32'h11, 1, 32'h55, 1, 7'b1000100, RAM,   32'h00, 32'h55);
    vecs[3]  = mk(0, 0, RAM, 32'h00, 0, 1, LED, 32'h11, 1, 32'h00, 0, 7'b0000000, RAM,   32'h00, 32'h55);
    vecs[4]  = mk(0, 0, RAM, 32'h00, 0, 1, LED, 32'h11, 1, 32'h00, 0, 7'b1110000, LED,   32'h11, 32'h55);
    vecs[5]  = mk(0, 0, RAM, 32'h00, 0, 1, LED, 32'h11, 1, 32'h99, 1, 7'b1100010, LED,   32'h11, 32'h55);
    vecs[6]  = mk(0, 1, LED, 32'hA0, 1, 1, LED, 32'hB1, 1, 32'h99, 1, 7'b0100000, LED,   32'h11, 32'h55);
    vecs[7]  = mk(0, 1, LED, 32'hA0, 1, 1, LED, 32'hB1, 1, 32'h99, 1, 7'b1010000, LED,   32'hA0, 32'h55);
    vecs[8]  = mk(0, 1, LED, 32'hA0, 1, 1, LED, 32'hB1, 1, 32'h99, 1, 7'b1000100, LED,   32'hA0, 32'h55);
    vecs[9]  = mk(0, 1, LED, 32'hA0, 1, 1, LED, 32'hB1, 1, 32'h99, 1, 7'b0000000, LED,   32'hA0, 32'h55);
    vecs[10] = mk(0, 1, LED, 32'hA0, 1, 1, LED, 32'hB1, 1, 32'h99, 1, 7'b1110000, LED,   32'hB1, 32'h55);
    vecs[11] = mk(0, 1, LED, 32'hA0, 1, 1, LED, 32'hB1, 1, 32'h99, 1, 7'b1100010, LED,   32'hB1, 32'h55);
    vecs[12] = mk(0, 1, LED, 32'hA0, 1, 1, LED, 32'hB1, 1, 32'h99, 1, 7'b0100000, LED,   32'hB1, 32'h55);
    vecs[13] = mk(0, 1, LED, 32'hA0, 1, 1, LED, 32'hB1, 1, 32'h99, 1, 7'b1010000, LED,   32'hA0, 32'h55);
    vecs[14] = mk(0, 1, LED, 32'hA0, 1, 1, LED, 32'hB1, 1, 32'h99, 1, 7'b1000100, LED,   32'hA0, 32'h55);
    vecs[15] = mk(0, 0, LED, 32'hA0, 1, 0, LED, 32'hB1, 1, 32'h00, 0, 7'b0000000, LED,   32'hA0, 32'h55);

    for (int i = 0; i < 16; i++) begin
      reset       = vecs[i].rst;
      bus.m0_req  = vecs[i].r0; bus.m0_addr = vecs[i].a0; bus.m0_wdata = vecs[i].d0; bus.m0_we = vecs[i].w0;
      bus.m1_req  = vecs[i].r1; bus.m1_addr = vecs[i].a1; bus.m1_wdata = vecs[i].d1; bus.m1_we = vecs[i].w1;
      bus.s_rdata = vecs[i].srd;
      bus.s_ready = vecs[i].srdy;
      step();
      chk($sformatf("vec%0d_flags", i),  {25'd0, flags_now()}, {25'd0, vecs[i].flags});
      chk($sformatf("vec%0d_s_addr", i), bus.s_addr,  vecs[i].saddr);
      chk($sformatf("vec%0d_s_wdata", i), bus.s_wdata, vecs[i].swdata);
      chk($sformatf("vec%0d_m_rdata", i), bus.m_rdata, vecs[i].rdata);
    end

    // DMA write with five wait states; owner drops req and CPU pokes req mid-ACCESS (both ignored).
    bus.m1_req = 1'b1; bus.m1_addr = 32'h4000_0004; bus.m1_wdata = 32'h1; bus.m1_we = 1'b1;
    bus.s_ready = 1'b0; bus.s_rdata = 32'h0;
    step();
    chk("t4_owner", {31'd0, bus.owner}, 32'd1);
    bus.m1_req = 1'b0; bus.m1_addr = '1; bus.m1_wdata = '1;
    bus.m0_req = 1'b1; bus.m0_addr = RAM; bus.m0_we = 1'b0;
    we_cnt = int'(bus.s_we); ack0_cnt = 0; ack1_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      we_cnt   += int'(bus.s_we);
      ack0_cnt += int'(bus.m0_ack);
      ack1_cnt += int'(bus.m1_ack);
    end
    chk("t4_s_addr_held", bus.s_addr, 32'h4000_0004);
    chk("t4_s_wdata_held", bus.s_wdata, 32'h1);
    bus.s_ready = 1'b1; bus.s_rdata = 32'hCAFE; bus.m0_req = 1'b0;
    step();
    we_cnt   += int'(bus.s_we);
    ack0_cnt += int'(bus.m0_ack);
    ack1_cnt += int'(bus.m1_ack);
    chk("t4_m_err", {31'd0, bus.m_err}, 32'd0);
    chk("t4_rdata_kept_on_write", bus.m_rdata, 32'h55);
    bus.s_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      we_cnt   += int'(bus.s_we);
      ack0_cnt += int'(bus.m0_ack);
      ack1_cnt += int'(bus.m1_ack);
    end
    chk("t4_we_cycles", we_cnt, 6);
    chk("t4_m1_acks", ack1_cnt, 1);
    chk("t4_m0_acks", ack0_cnt, 0);
    chk("t4_busy_after", {31'd0, bus.busy}, 32'd0);

    // Zero-wait CPU read of the timer, leaves the round-robin pointer on DMA.
    bus.m0_req = 1'b1; bus.m0_addr = TIMER; bus.m0_we = 1'b0;
    step();
    chk("rd_s_re", {31'd0, bus.s_re}, 32'd1);
    bus.s_ready = 1'b1; bus.s_rdata = 32'h1234;
    step();
    chk("rd_m0_ack", {31'd0, bus.m0_ack}, 32'd1);
    chk("rd_m_rdata", bus.m_rdata, 32'h1234);
    bus.m0_req = 1'b0; bus.s_ready = 1'b0;
    step();

    // Asynchronous reset mid-ACCESS: outputs drop before the next edge, no ack, pointer back to CPU.
    bus.m1_req = 1'b1; bus.m1_addr = LED; bus.m1_we = 1'b0;
    step();
    chk("t6_pre_owner", {31'd0, bus.owner}, 32'd1);
    #2;
    reset = 1'b1;
    bus.s_ready = 1'b1; bus.s_rdata = 32'h77;
    bus.m0_req = 1'b1; bus.m0_addr = RAM; bus.m0_we = 1'b0;
    #1;
    chk("t6_async_flags", {25'd0, flags_now()}, 32'd0);
    chk("t6_async_s_addr", bus.s_addr, 32'd0);
    chk("t6_async_rdata", bus.m_rdata, 32'd0);
    ack0_cnt = 0; ack1_cnt = 0;
    step();
    ack0_cnt += int'(bus.m0_ack);
    ack1_cnt += int'(bus.m1_ack);
    reset = 1'b0;
    step();
    ack0_cnt += int'(bus.m0_ack);
    ack1_cnt += int'(bus.m1_ack);
    chk("t6_no_ack", ack0_cnt + ack1_cnt, 0);
    chk("t6_regrant_flags", {25'd0, flags_now()}, {25'd0, 7'b1001000});
    bus.m1_req = 1'b0;
    step();
    chk("t6_m0_ack", {25'd0, flags_now()}, {25'd0, 7'b1000100});
    chk("t6_m_rdata", bus.m_rdata, 32'h77);
    bus.m0_req = 1'b0; bus.s_ready = 1'b0;
    step();

    // Stalled slave: abort after TIMEOUT cycles when enabled, otherwise wait indefinitely.
    bus.m0_req = 1'b1; bus.m0_addr = TIMER; bus.m0_we = 1'b0;
    step();
    bus.m0_req = 1'b0;
    n = 0;
    found = 1'b0;
`ifdef ARB_TIMEOUT_EN
    while (!found && n < 40) begin
      step();
      n++;
      if (bus.m0_ack) found = 1'b1;
    end
    chk("t5_ack_seen", {31'd0, found}, 32'd1);
    chk("t5_access_cycles", n, 16);
    chk("t5_m_err", {31'd0, bus.m_err}, 32'd1);
    chk("t5_m_rdata", bus.m_rdata, 32'hDEAD_BEEF);
    chk("t5_strobes", {30'd0, bus.s_we, bus.s_re}, 32'd0);
    step();
    chk("t5_busy_after", {31'd0, bus.busy}, 32'd0);
`else
    while (n < 40) begin
      step();
      n++;
      if (bus.m0_ack || bus.m1_ack) found = 1'b1;
    end
    chk("t5_no_ack_while_stalled", {31'd0, found}, 32'd0);
    chk("t5_still_busy", {30'd0, bus.busy, bus.s_re}, 32'd3);
    bus.s_ready = 1'b1; bus.s_rdata = 32'hAB;
    step();
    chk("t5_late_ack", {25'd0, flags_now()}, {25'd0, 7'b1000100});
    chk("t5_m_rdata", bus.m_rdata, 32'hAB);
    bus.s_ready = 1'b0;
    step();
    chk("t5_busy_after", {31'd0, bus.busy}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
